// File: rtl/score_disp_pkg.sv
// rtl/score_disp_pkg.sv - shared types and default geometry for the score digit renderer
// Holds the RGB444 pixel and BCD nibble types, the blank pixel value and the
// default parameter values used by score_digit_renderer and bin2bcd_seq.
package score_disp_pkg;

    typedef logic [11:0] rgb444_t;
    typedef logic [3:0]  bcd_t;

    localparam rgb444_t BLANK_PIXEL = 12'h000;

    localparam int SCORE_W_DEF    = 14;
    localparam int DIGITS_DEF     = 4;
    localparam int GLYPH_W_DEF    = 15;
    localparam int GLYPH_H_DEF    = 30;
    localparam int ROM_STRIDE_DEF = 150;
    localparam int ROM_AW_DEF     = 17;

endpackage

// File: rtl/bin2bcd_seq.sv
// rtl/bin2bcd_seq.sv - sequential double-dabble binary to BCD converter with saturation
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   score       : binary input, converted whenever it differs from the last captured value
//   shown_bcd   : displayed BCD digits, most significant nibble at the top, changes only on LOAD
//   conv_busy   : high from capture until the result is loaded
module bin2bcd_seq
    import score_disp_pkg::*;
#(
    parameter int SCORE_W = SCORE_W_DEF,
    parameter int DIGITS  = DIGITS_DEF
)(
    input  logic                clk,
    input  logic                rst_n,
    input  logic [SCORE_W-1:0]  score,
    output logic [DIGITS*4-1:0] shown_bcd,
    output logic                conv_busy
);

    localparam int CW = (SCORE_W > 1) ? $clog2(SCORE_W) : 1;
    localparam int SW = (DIGITS + 1) * 4;

    typedef enum logic [1:0] {S_IDLE, S_CONV, S_LOAD} state_t;

    state_t               state_q, state_d;
    logic [SCORE_W-1:0]   last_score_q, last_score_d;
    logic [SCORE_W-1:0]   shift_q, shift_d;
    logic [SW-1:0]        scratch_q, scratch_d;
    logic                 ovf_q, ovf_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [DIGITS*4-1:0]  shown_q, shown_d;
    logic                 busy_q, busy_d;
    logic [SW-1:0]        adj;
    bcd_t                 nib;

    always_comb begin
        state_d      = state_q;
        last_score_d = last_score_q;
        shift_d      = shift_q;
        scratch_d    = scratch_q;
        ovf_d        = ovf_q;
        cnt_d        = cnt_q;
        shown_d      = shown_q;
        busy_d       = busy_q;
        adj          = scratch_q;
        nib          = '0;

        for (int i = 0; i <= DIGITS; i++) begin
            nib = scratch_q[i*4 +: 4];
            adj[i*4 +: 4] = (nib >= 4'd5) ? nib + 4'd3 : nib;
        end

        case (state_q)
            S_IDLE: begin
                if (score != last_score_q) begin
                    last_score_d = score;
                    shift_d      = score;
                    scratch_d    = '0;
                    ovf_d        = 1'b0;
                    cnt_d        = '0;
                    busy_d       = 1'b1;
                    state_d      = S_CONV;
                end
            end
            S_CONV: begin
                scratch_d = {adj[SW-2:0], shift_q[SCORE_W-1]};
                // A bit falling off the top means the value outgrew even the guard nibble.
                ovf_d     = ovf_q | adj[SW-1];
                shift_d   = shift_q << 1;
                cnt_d     = cnt_q + CW'(1);
                if (cnt_q == CW'(SCORE_W - 1)) begin
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                // Guard nibble non-zero means the value needs more than DIGITS digits.
                if (ovf_q || (scratch_q[DIGITS*4 +: 4] != 4'd0)) begin
                    shown_d = {DIGITS{4'h9}};
                end else begin
                    shown_d = scratch_q[DIGITS*4-1:0];
                end
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            last_score_q <= '0;
            shift_q      <= '0;
            scratch_q    <= '0;
            ovf_q        <= 1'b0;
            cnt_q        <= '0;
            shown_q      <= '0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_score_q <= last_score_d;
            shift_q      <= shift_d;
            scratch_q    <= scratch_d;
            ovf_q        <= ovf_d;
            cnt_q        <= cnt_d;
            shown_q      <= shown_d;
            busy_q       <= busy_d;
        end
    end

    assign shown_bcd = shown_q;
    assign conv_busy = busy_q;

endmodule

// File: rtl/score_digit_renderer.sv
// rtl/score_digit_renderer.sv - renders a binary score as decimal glyphs into the VGA pixel stream
// Optional build macro: LEADING_ZERO_BLANK_EN blanks leading zero digits (except the last).
// Ports:
//   clk_25MHz, rst_n       : pixel clock, asynchronous active-low reset
//   score                  : binary score to display
//   score_x, score_y       : top-left corner of the digit window
//   h_cnt, v_cnt           : current raster position
//   rom_addr / rom_data    : glyph ROM address (stage 1) and its read data
//   pixel_score/pixel_valid: RGB444 pixel and window flag, two cycles after h_cnt/v_cnt
//   conv_busy              : binary to BCD conversion in progress
module score_digit_renderer
    import score_disp_pkg::*;
#(
    parameter int SCORE_W    = SCORE_W_DEF,
    parameter int DIGITS     = DIGITS_DEF,
    parameter int GLYPH_W    = GLYPH_W_DEF,
    parameter int GLYPH_H    = GLYPH_H_DEF,
    parameter int ROM_STRIDE = ROM_STRIDE_DEF,
    parameter int ROM_AW     = ROM_AW_DEF
)(
    input  logic               clk_25MHz,
    input  logic               rst_n,
    input  logic [SCORE_W-1:0] score,
    input  logic [9:0]         score_x,
    input  logic [9:0]         score_y,
    input  logic [9:0]         h_cnt,
    input  logic [9:0]         v_cnt,
    output logic [ROM_AW-1:0]  rom_addr,
    input  logic [11:0]        rom_data,
    output logic [11:0]        pixel_score,
    output logic               pixel_valid,
    output logic               conv_busy
);

    localparam int CW    = (GLYPH_W > 1) ? $clog2(GLYPH_W) : 1;
    localparam int DW    = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int WIN_W = DIGITS * GLYPH_W;

    logic [DIGITS*4-1:0] shown_bcd;

    bin2bcd_seq #(
        .SCORE_W (SCORE_W),
        .DIGITS  (DIGITS)
    ) u_bin2bcd (
        .clk       (clk_25MHz),
        .rst_n     (rst_n),
        .score     (score),
        .shown_bcd (shown_bcd),
        .conv_busy (conv_busy)
    );

    logic [CW-1:0]     col_q, col_d, cur_col;
    logic [DW-1:0]     dig_q, dig_d, cur_dig;
    logic [ROM_AW-1:0] rom_addr_q, rom_addr_d;
    logic              win_q, win_d;
    logic              blank_q, blank_d;
    rgb444_t           pix_q, pix_d;
    logic              pvalid_q, pvalid_d;
    logic              at_left, in_x, in_y, lz;
    logic [9:0]        row;
    bcd_t              cur_nib;

    always_comb begin
        at_left = (h_cnt == score_x);
        // The registered counters already hold the position for this h_cnt; the
        // left edge of the window forces them back to zero.
        cur_col = at_left ? '0 : col_q;
        cur_dig = at_left ? '0 : dig_q;

        col_d = cur_col + CW'(1);
        dig_d = cur_dig;
        if (cur_col == CW'(GLYPH_W - 1)) begin
            col_d = '0;
            if (cur_dig != DW'(DIGITS - 1)) begin
                dig_d = cur_dig + DW'(1);
            end
        end

        in_x = ({2'b00, h_cnt} >= {2'b00, score_x}) &&
               ({2'b00, h_cnt} <  {2'b00, score_x} + 12'(WIN_W));
        in_y = ({2'b00, v_cnt} >= {2'b00, score_y}) &&
               ({2'b00, v_cnt} <  {2'b00, score_y} + 12'(GLYPH_H));
        win_d = in_x && in_y;
        row   = v_cnt - score_y;

        // Digit index 0 is the most significant nibble of the shown value.
        cur_nib = shown_bcd[(DIGITS - 1 - int'(cur_dig)) * 4 +: 4];

        rom_addr_d = '0;
        if (win_d) begin
            rom_addr_d = ROM_AW'(32'(cur_col) + 32'(cur_nib) * GLYPH_W + 32'(row) * ROM_STRIDE);
        end

        lz      = 1'b1;
        blank_d = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
        for (int i = 0; i < DIGITS - 1; i++) begin
            lz = lz && (shown_bcd[(DIGITS - 1 - i) * 4 +: 4] == 4'd0);
            if (DW'(i) == cur_dig) begin
                blank_d = lz;
            end
        end
`else
        blank_d = 1'b0;
`endif

        pix_d    = (win_q && !blank_q) ? rom_data : BLANK_PIXEL;
        pvalid_d = win_q;
    end

    always_ff @(posedge clk_25MHz or negedge rst_n) begin
        if (!rst_n) begin
            col_q      <= '0;
            dig_q      <= '0;
            rom_addr_q <= '0;
            win_q      <= 1'b0;
            blank_q    <= 1'b0;
            pix_q      <= BLANK_PIXEL;
            pvalid_q   <= 1'b0;
        end else begin
            col_q      <= col_d;
            dig_q      <= dig_d;
            rom_addr_q <= rom_addr_d;
            win_q      <= win_d;
            blank_q    <= blank_d;
            pix_q      <= pix_d;
            pvalid_q   <= pvalid_d;
        end
    end

    assign rom_addr    = rom_addr_q;
    assign pixel_score = pix_q;
    assign pixel_valid = pvalid_q;

endmodule

// File: tb/tb_score_digit_renderer.sv
// tb/tb_score_digit_renderer.sv - scoreboard bench for score_digit_renderer
module tb_score_digit_renderer;

    localparam int SW = 14;
    localparam int ND = 4;
    localparam int GW = 15;
    localparam int GH = 30;
    localparam int RS = 150;
    localparam int AW = 17;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [SW-1:0] score;
    logic [9:0]    score_x, score_y, h_cnt, v_cnt;
    logic [AW-1:0] rom_addr;
    logic [11:0]   rom_data, pixel_score;
    logic          pixel_valid, conv_busy;

    always #5 clk = ~clk;

    score_digit_renderer #(
        .SCORE_W(SW), .DIGITS(ND), .GLYPH_W(GW), .GLYPH_H(GH), .ROM_STRIDE(RS), .ROM_AW(AW)
    ) dut (
        .clk_25MHz   (clk),
        .rst_n       (rst_n),
        .score       (score),
        .score_x     (score_x),
        .score_y     (score_y),
        .h_cnt       (h_cnt),
        .v_cnt       (v_cnt),
        .rom_addr    (rom_addr),
        .rom_data    (rom_data),
        .pixel_score (pixel_score),
        .pixel_valid (pixel_valid),
        .conv_busy   (conv_busy)
    );

    function automatic logic [11:0] rom_fn(input logic [AW-1:0] a);
        return 12'((a * 17'd37) ^ (a >> 5) ^ 17'h5a5);
    endfunction

    // rom_addr is the ROM's registered address, so its word is ready for stage 2.
    assign rom_data = rom_fn(rom_addr);

    typedef struct {
        int addr;
        int pix;
    } exp_t;

    exp_t          sb[$];
    int            total = 0;
    int            bad = 0;
    bit            mon_en = 1'b0;
    logic [AW-1:0] prev_addr = '0;
    int            disp = 0;
    int            last_score = 0;
    int            sx, sy;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic int p10(input int n);
        int r = 1;
        for (int k = 0; k < n; k++) r = r * 10;
        return r;
    endfunction

    always @(negedge clk) begin
        if (mon_en && rst_n) begin
            if (pixel_valid) begin
                if (sb.size() == 0) begin
                    chk("unexpected_valid", 1, 0);
                end else begin
                    chk("rom_addr", int'(prev_addr), sb[0].addr);
                    chk("pixel", int'(pixel_score), sb[0].pix);
                    sb.delete(0);
                end
            end else begin
                chk("idle_pixel", int'(pixel_score), 0);
                chk("idle_addr", int'(prev_addr), 0);
            end
        end
        prev_addr <= rom_addr;
    end

    task automatic drive_px(input int h, input int v);
        int x, di, col, row, dv, addr;
        bit blank;
        @(posedge clk);
        #1;
        h_cnt = 10'(h);
        v_cnt = 10'(v);
        if (h >= sx && h < sx + ND * GW && v >= sy && v < sy + GH) begin
            x     = h - sx;
            di    = x / GW;
            col   = x % GW;
            row   = v - sy;
            dv    = (disp / p10(ND - 1 - di)) % 10;
            addr  = col + dv * GW + row * RS;
            blank = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
            if (di < ND - 1 && disp < p10(ND - 1 - di)) blank = 1'b1;
`endif
            sb.push_back('{addr, blank ? 0 : int'(rom_fn(AW'(addr)))});
        end
    endtask

    task automatic render();
        for (int v = sy - 1; v <= sy + GH; v++)
            for (int h = sx - 2; h < sx + ND * GW + 2; h++)
                drive_px(h, v);
        for (int k = 0; k < 4; k++) drive_px(0, 0);
    endtask

    task automatic conv_wait(output int lead, output int len);
        lead = 0;
        len  = 0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (conv_busy) len++;
            else if (len > 0) break;
            else lead++;
        end
    endtask

    task automatic new_score(input int s);
        int lead, len;
        @(posedge clk);
        #1;
        score = SW'(s);
        if (s != last_score) begin
            conv_wait(lead, len);
            chk("conv_start", lead, 1);
            chk("conv_len", len, SW + 1);
        end else begin
            repeat (20) @(posedge clk);
            @(negedge clk);
            chk("no_conv", int'(conv_busy), 0);
        end
        last_score = s;
        disp = (s > p10(ND) - 1) ? p10(ND) - 1 : s;
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        int lead, len, s;
        rst_n = 1'b0; score = '0; score_x = 10'd100; score_y = 10'd50;
        sx = 100; sy = 50; h_cnt = '0; v_cnt = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_rom_addr", int'(rom_addr), 0);
        chk("rst_pixel", int'(pixel_score), 0);
        chk("rst_valid", int'(pixel_valid), 0);
        chk("rst_busy", int'(conv_busy), 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (20) @(posedge clk);
        @(negedge clk);
        chk("busy_after_rst", int'(conv_busy), 0);
        mon_en = 1'b1;
        render();

        new_score(1234);  render();
        new_score(12000); render();
        new_score(42);    render();

        // 5 captured, then 6 arrives while the first conversion runs.
        @(posedge clk);
        #1 score = SW'(5);
        @(posedge clk);
        #1 score = SW'(6);
        conv_wait(lead, len);
        chk("first_lead", lead, 0);
        chk("first_len", len, SW + 1);
        conv_wait(lead, len);
        chk("second_lead", lead, 0);
        chk("second_len", len, SW + 1);
        last_score = 6; disp = 6;
        render();

        // Reset during the seventh conversion cycle of 999.
        @(posedge clk);
        #1 score = SW'(999);
        for (int k = 0; k < 50 && !conv_busy; k++) @(negedge clk);
        repeat (6) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("midrst_busy", int'(conv_busy), 0);
        chk("midrst_addr", int'(rom_addr), 0);
        chk("midrst_pixel", int'(pixel_score), 0);
        chk("midrst_valid", int'(pixel_valid), 0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        conv_wait(lead, len);
        chk("rst_reconv_len", len, SW + 1);
        last_score = 999; disp = 999;
        render();

        new_score(9999);  render();
        new_score(10000); render();

        for (int n = 0; n < 5; n++) begin
            s = int'($urandom_range(0, 16383));
            sx = int'($urandom_range(2, 900));
            sy = int'($urandom_range(1, 400));
            score_x = 10'(sx);
            score_y = 10'(sy);
            new_score(s);
            render();
        end

        for (int k = 0; k < 5; k++) drive_px(0, 0);
        chk("sb_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
